// File: rtl/gf180mcu_osu_sc_gp12t3v3__bufbank_seq.sv
// Staggered enable sequencer for a segmented buf_16 bank: segments are switched one per step.
// Optional synchronous KILL input is compiled in when GF180_BUFSEQ_KILL_EN is defined.
module gf180mcu_osu_sc_gp12t3v3__bufbank_seq #(
  parameter int N_SEG  = 8,
  parameter int STEP_W = 4
) (
  input  logic              CLK,
  input  logic              RN,
`ifdef GF180_BUFSEQ_KILL_EN
  input  logic              KILL,
`endif
  input  logic              EN,
  input  logic [STEP_W-1:0] STEP_DLY,
  output logic [N_SEG-1:0]  SEG_EN,
  output logic              READY,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_ON   = 2'd2,
    ST_DOWN = 2'd3
  } state_t;

  localparam logic [N_SEG-1:0]  SEG_FULL = {N_SEG{1'b1}};
  localparam logic [N_SEG-1:0]  SEG_NONE = {N_SEG{1'b0}};
  localparam logic [STEP_W-1:0] CNT_ZERO = {STEP_W{1'b0}};
  localparam logic [STEP_W-1:0] CNT_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  state_t             state_s;
  logic [N_SEG-1:0]   seg_r;
  logic [N_SEG-1:0]   seg_s;
  logic [STEP_W-1:0]  cnt_r;
  logic [STEP_W-1:0]  cnt_s;
  logic               ready_r;
  logic               ready_s;
  logic               busy_r;
  logic               busy_s;
  logic               kill_s;
  logic               step_ok_s;
  logic               up_due_s;
  logic               down_due_s;
  logic               full_nx_s;
  logic               empty_nx_s;

  function automatic logic [N_SEG-1:0] therm_up(input logic [N_SEG-1:0] v);
    return {v[N_SEG-2:0], 1'b1};
  endfunction

  function automatic logic [N_SEG-1:0] therm_down(input logic [N_SEG-1:0] v);
    return {1'b0, v[N_SEG-1:1]};
  endfunction

`ifdef GF180_BUFSEQ_KILL_EN
  assign kill_s = KILL;
`else
  assign kill_s = 1'b0;
`endif

  // Step decision, thermometer update and step-gap timer.
  always_comb begin
    seg_s      = seg_r;
    cnt_s      = cnt_r;
    step_ok_s  = (cnt_r == CNT_ZERO);
    up_due_s   = EN && (seg_r != SEG_FULL);
    down_due_s = !EN && (seg_r != SEG_NONE);
    if (step_ok_s && up_due_s) begin
      seg_s = therm_up(seg_r);
    end else if (step_ok_s && down_due_s) begin
      seg_s = therm_down(seg_r);
    end else begin
      seg_s = seg_r;
    end
    // The gap is measured from the last change, so reversals never reload the timer.
    if (seg_s != seg_r) begin
      cnt_s = STEP_DLY;
    end else if (!step_ok_s) begin
      cnt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_s = CNT_ZERO;
    end
  end

  // Next-state selection from the request and the post-step thermometer.
  always_comb begin
    state_s    = state_r;
    full_nx_s  = (seg_s == SEG_FULL);
    empty_nx_s = (seg_s == SEG_NONE);
    case (state_r)
      ST_IDLE: begin
        if (EN) begin
          state_s = full_nx_s ? ST_ON : ST_UP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_UP, ST_DOWN: begin
        if (EN) begin
          state_s = full_nx_s ? ST_ON : ST_UP;
        end else begin
          state_s = empty_nx_s ? ST_IDLE : ST_DOWN;
        end
      end
      ST_ON: begin
        if (EN) begin
          state_s = ST_ON;
        end else begin
          state_s = empty_nx_s ? ST_IDLE : ST_DOWN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Status flags are computed from the next state so they register alongside it.
  always_comb begin
    ready_s = 1'b0;
    busy_s  = 1'b0;
    if ((state_s == ST_ON) && EN) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    if ((state_s == ST_UP) || (state_s == ST_DOWN)) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  // State, thermometer, timer and status registers; KILL bypasses step spacing.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_r <= ST_IDLE;
      seg_r   <= SEG_NONE;
      cnt_r   <= CNT_ZERO;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else if (kill_s) begin
      state_r <= ST_IDLE;
      seg_r   <= SEG_NONE;
      cnt_r   <= CNT_ZERO;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      seg_r   <= seg_s;
      cnt_r   <= cnt_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
    end
  end

  assign SEG_EN = seg_r;
  assign READY  = ready_r;
  assign BUSY   = busy_r;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__bufbank_seq.sv
// Directed bench for the buffer-bank enable sequencer: vector table plus corner-case sequences.
module tb_gf180mcu_osu_sc_gp12t3v3__bufbank_seq;

  logic       CLK = 1'b0;
  logic       RN;
  logic       EN;
  logic       KILL;
  logic [3:0] STEP_DLY;
  logic [7:0] SEG_EN;
  logic       READY;
  logic       BUSY;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       en;
    logic [3:0] dly;
    logic [7:0] seg;
    logic       ready;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  always #5 CLK = ~CLK;

  gf180mcu_osu_sc_gp12t3v3__bufbank_seq #(.N_SEG(8), .STEP_W(4)) dut (
    .CLK      (CLK),
    .RN       (RN),
`ifdef GF180_BUFSEQ_KILL_EN
    .KILL     (KILL),
`endif
    .EN       (EN),
    .STEP_DLY (STEP_DLY),
    .SEG_EN   (SEG_EN),
    .READY    (READY),
    .BUSY     (BUSY)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Compares {BUSY, READY, SEG_EN} against the expected triple.
  task automatic check(input string name, input logic [7:0] seg, input logic ready, input logic busy);
    logic [9:0] got;
    logic [9:0] exp;
    got = {BUSY, READY, SEG_EN};
    exp = {busy, ready, seg};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got busy/ready/seg=%b/%b/%h expected %b/%b/%h",
               name, got[9], got[8], got[7:0], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic add(input logic en, input logic [3:0] dly, input logic [7:0] seg,
                     input logic ready, input logic busy);
    vec_t v;
    v.en = en; v.dly = dly; v.seg = seg; v.ready = ready; v.busy = busy;
    vecs.push_back(v);
  endtask

  initial begin
    // Ramp-up with STEP_DLY=3: bit k set at edge 4k, full at edge 28.
    for (int e = 0; e < 29; e++) add(1'b1, 4'd3, 8'((2 << (e / 4)) - 1), e == 28, e < 28);
    for (int e = 0; e < 4; e++)  add(1'b1, 4'd3, 8'hFF, 1'b1, 1'b0);
    // Ramp-down symmetric, empty at edge 28.
    for (int e = 0; e < 29; e++) add(1'b0, 4'd3, 8'(8'hFF >> (e / 4 + 1)), 1'b0, e < 28);
    for (int e = 0; e < 4; e++)  add(1'b0, 4'd3, 8'h00, 1'b0, 1'b0);
    // Reversal: up at edge 0, EN low sampled at edge 5, next change at 8, empty at 12.
    add(1'b1, 4'd3, 8'h01, 1'b0, 1'b1);
    for (int e = 1; e < 4; e++)  add(1'b1, 4'd3, 8'h01, 1'b0, 1'b1);
    add(1'b1, 4'd3, 8'h03, 1'b0, 1'b1);
    for (int e = 5; e < 8; e++)  add(1'b0, 4'd3, 8'h03, 1'b0, 1'b1);
    for (int e = 8; e < 12; e++) add(1'b0, 4'd3, 8'h01, 1'b0, 1'b1);
    add(1'b0, 4'd3, 8'h00, 1'b0, 1'b0);
    for (int e = 0; e < 4; e++)  add(1'b0, 4'd3, 8'h00, 1'b0, 1'b0);
    // STEP_DLY=0: one segment per cycle, full at edge 7, then straight back down.
    for (int e = 0; e < 8; e++)  add(1'b1, 4'd0, 8'((2 << e) - 1), e == 7, e < 7);
    for (int e = 0; e < 8; e++)  add(1'b0, 4'd0, 8'(8'hFF >> (e + 1)), 1'b0, e < 7);

    RN = 1'b0; EN = 1'b0; KILL = 1'b0; STEP_DLY = 4'd3;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", 8'h00, 1'b0, 1'b0);
    RN = 1'b1;
    tick();
    check("post_reset_idle", 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      EN = vecs[i].en;
      STEP_DLY = vecs[i].dly;
      tick();
      check($sformatf("vec%0d", i), vecs[i].seg, vecs[i].ready, vecs[i].busy);
    end

    // STEP_DLY=15: bit k at edge 16k, full at 112.
    EN = 1'b1; STEP_DLY = 4'd15;
    for (int e = 0; e <= 112; e++) begin
      tick();
      if (e == 0 || e == 15 || e == 16 || e == 111 || e == 112)
        check($sformatf("dly15_edge%0d", e), 8'((2 << (e / 16)) - 1), e == 112, e < 112);
    end
    repeat (16) tick();
    check("dly15_hold_on", 8'hFF, 1'b1, 1'b0);
    EN = 1'b0;
    tick();
    check("dly15_down0", 8'h7F, 1'b0, 1'b1);
    // Shortening STEP_DLY mid-gap must not cut the running 16-cycle gap.
    STEP_DLY = 4'd0;
    repeat (14) tick();
    tick();
    check("midgap_edge15", 8'h7F, 1'b0, 1'b1);
    tick();
    check("midgap_edge16", 8'h3F, 1'b0, 1'b1);
    tick();
    check("midgap_edge17", 8'h1F, 1'b0, 1'b1);
    repeat (4) tick();
    tick();
    check("midgap_empty", 8'h00, 1'b0, 1'b0);

    // Reset in the middle of a ramp drops everything at once.
    STEP_DLY = 4'd3; EN = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      tick();
      if (e == 10) check("pre_reset_edge10", 8'h07, 1'b0, 1'b1);
    end
    RN = 1'b0;
    #1;
    check("async_reset_immediate", 8'h00, 1'b0, 1'b0);
    repeat (2) tick();
    check("reset_held", 8'h00, 1'b0, 1'b0);
    RN = 1'b1;
    tick();
    check("reset_restart", 8'h01, 1'b0, 1'b1);

`ifdef GF180_BUFSEQ_KILL_EN
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 12) check("pre_kill", 8'h0F, 1'b0, 1'b1);
    end
    KILL = 1'b1;
    tick();
    check("kill_edge", 8'h00, 1'b0, 1'b0);
    KILL = 1'b0;
    tick();
    check("after_kill", 8'h01, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
